// File: rtl/latch_q_debounce_if.sv
// latch_q_debounce_if
// Bundles the signals exchanged between the debouncer and the logic around it.
// The build macro LQD_GLITCH_CNT_EN adds the glitch_cnt signal.
//   q_in, nq_in  : latch complementary outputs, asynchronous to clk
//   clr          : synchronous clear of the counters and the pair error flag
//   level_out    : debounced q level
//   rise_pulse   : one-cycle pulse on a committed 0->1 change
//   fall_pulse   : one-cycle pulse on a committed 1->0 change
//   edge_cnt     : committed edge count
//   pair_err     : sticky q/nq non-complementary flag
//   glitch_cnt   : aborted debounce count (LQD_GLITCH_CNT_EN only)
// modport slave is the debouncer; modport master is whoever drives the inputs.
interface latch_q_debounce_if #(
    parameter int CNT_W = 8
);
    logic             q_in;
    logic             nq_in;
    logic             clr;
    logic             level_out;
    logic             rise_pulse;
    logic             fall_pulse;
    logic [CNT_W-1:0] edge_cnt;
    logic             pair_err;
`ifdef LQD_GLITCH_CNT_EN
    logic [CNT_W-1:0] glitch_cnt;
`endif

    modport slave (
        input  q_in, nq_in, clr,
`ifdef LQD_GLITCH_CNT_EN
        output glitch_cnt,
`endif
        output level_out, rise_pulse, fall_pulse, edge_cnt, pair_err
    );

    modport master (
        output q_in, nq_in, clr,
`ifdef LQD_GLITCH_CNT_EN
        input  glitch_cnt,
`endif
        input  level_out, rise_pulse, fall_pulse, edge_cnt, pair_err
    );
endinterface

// File: rtl/latch_q_debounce.sv
// latch_q_debounce
// Consumes the complementary q/nq outputs of a latch. It does four things:
//   - synchronises both outputs into clk
//   - debounces q into level_out, with one-cycle rise/fall pulses
//   - counts committed edges in edge_cnt
//   - raises a sticky pair_err when q and nq are seen equal on two consecutive cycles
// Ports:
//   clk    : system clock, rising edge
//   rst_n  : asynchronous active-low reset
//   bus    : latch_q_debounce_if.slave carrying q_in/nq_in/clr and the outputs
// Build option LQD_GLITCH_CNT_EN: adds a saturating glitch_cnt counting aborted debounces.
//
// state     | meaning
// STABLE_LO | level_out=0, q_s agrees
// WAIT_HI   | q_s went 1, counting consecutive high samples
// STABLE_HI | level_out=1, q_s agrees
// WAIT_LO   | q_s went 0, counting consecutive low samples
module latch_q_debounce #(
    parameter int DEBOUNCE_CYCLES = 4,
    parameter int CNT_W           = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    latch_q_debounce_if.slave  bus
);
    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES);

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        WAIT_HI   = 2'd1,
        STABLE_HI = 2'd2,
        WAIT_LO   = 2'd3
    } state_t;

    logic             q_s1, q_s, nq_s1, nq_s;
    state_t           state, state_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             level_r, level_nxt;
    logic             rise_r, rise_nxt;
    logic             fall_r, fall_nxt;
    logic [CNT_W-1:0] edge_cnt_r;
    logic [1:0]       warm;
    logic             eq_now, eq_d, pair_r;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_s1    <= 1'b0;
            q_s     <= 1'b0;
            nq_s1   <= 1'b0;
            nq_s    <= 1'b0;
            state   <= STABLE_LO;
            cnt     <= '0;
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            q_s1    <= bus.q_in;
            q_s     <= q_s1;
            nq_s1   <= bus.nq_in;
            nq_s    <= nq_s1;
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            level_r <= level_nxt;
            rise_r  <= rise_nxt;
            fall_r  <= fall_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        level_nxt = level_r;
        rise_nxt  = 1'b0;
        fall_nxt  = 1'b0;
        case (state)
            STABLE_LO: begin
                if (q_s) begin
                    state_nxt = WAIT_HI;
                    cnt_nxt   = CW'(1);
                end
            end
            WAIT_HI: begin
                if (!q_s) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                    level_nxt = 1'b1;
                    rise_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            STABLE_HI: begin
                if (!q_s) begin
                    state_nxt = WAIT_LO;
                    cnt_nxt   = CW'(1);
                end
            end
            WAIT_LO: begin
                if (q_s) begin
                    state_nxt = STABLE_HI;
                    cnt_nxt   = '0;
                end else if (cnt == CNT_MAX) begin
                    state_nxt = STABLE_LO;
                    cnt_nxt   = '0;
                    level_nxt = 1'b0;
                    fall_nxt  = 1'b1;
                end else begin
                    cnt_nxt = cnt + 1'b1;
                end
            end
            default: begin
                state_nxt = STABLE_LO;
                cnt_nxt   = '0;
            end
        endcase
    end

    // The edge count advances on the same clock edge that registers the pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            edge_cnt_r <= '0;
        else if (bus.clr)
            edge_cnt_r <= '0;
        else if (rise_nxt || fall_nxt)
            edge_cnt_r <= edge_cnt_r + 1'b1;
    end

    // Both sync chains reset to 0, which looks like an equal q/nq pair for
    // the first two cycles after reset. Comparison waits until both chains
    // hold real samples so a healthy latch never trips pair_err at start-up.
    assign eq_now = (q_s == nq_s) && (warm == 2'd2);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            warm   <= 2'd0;
            eq_d   <= 1'b0;
            pair_r <= 1'b0;
        end else begin
            if (warm != 2'd2)
                warm <= warm + 2'd1;
            eq_d <= eq_now;
            if (bus.clr)
                pair_r <= 1'b0;
            else if (eq_now && eq_d)
                pair_r <= 1'b1;
        end
    end

`ifdef LQD_GLITCH_CNT_EN
    logic             abort;
    logic [CNT_W-1:0] glitch_cnt_r;

    assign abort = ((state == WAIT_HI) && !q_s) || ((state == WAIT_LO) && q_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            glitch_cnt_r <= '0;
        else if (bus.clr)
            glitch_cnt_r <= '0;
        else if (abort && (glitch_cnt_r != {CNT_W{1'b1}}))
            glitch_cnt_r <= glitch_cnt_r + 1'b1;
    end

    assign bus.glitch_cnt = glitch_cnt_r;
`endif

    assign bus.level_out  = level_r;
    assign bus.rise_pulse = rise_r;
    assign bus.fall_pulse = fall_r;
    assign bus.edge_cnt   = edge_cnt_r;
    assign bus.pair_err   = pair_r;
endmodule
